multi_timer: RTL
================

# multi_timer

Parametrised machine-timer successor: a free-running, prescaled CNT_WIDTH-bit counter with NUM_CH independent compare channels. Each channel runs in one-shot or periodic (auto-reload) mode and has a sticky, individually-enabled interrupt. It sits on the peripheral memory bus as a memory-mapped slave. It drives a combined interrupt line to the core plus a per-channel vector for the interrupt controller.

## Interface
- BASE_ADDR, 32'h40003000, base of the 256-byte register window; decode is mem_addr[31:8] == BASE_ADDR[31:8].
- NUM_CH, 4, number of compare channels, 1..8.
- CNT_WIDTH, 48, counter/compare width, 33..64.
- clk  in  1  system clock; the block's only clock.
- rst  in  1  reset; asynchronous, active-high.
- mem_addr  in  32  byte address; word-aligned, bits[1:0] ignored.
- mem_wdata  in  32  write data.
- mem_we  in  1  write strobe, one cycle per access.
- mem_re  in  1  read strobe, one cycle per access.
- mem_rdata  out  32  read data; combinational; 0 unless addr matches and mem_re.
- irq  out  1  OR of (STATUS & IRQ_EN).
- irq_vec  out  NUM_CH  STATUS & IRQ_EN per channel.

## Operation
- Global registers, as offsets from the base:
  - 0x00 CTRL. Bit0 EN. Bits[31:16] PRESCALE. Counter advances once every PRESCALE+1 clk cycles while EN=1.
  - 0x04 CNT_LO and 0x08 CNT_HI. CNT_HI holds bits [CNT_WIDTH-1:32], zero-padded.
  - 0x0C STATUS. Sticky per-channel bits; writing 1 clears (W1C).
  - 0x10 IRQ_EN.
- Channel k occupies 0x20+0x10*k:
  - +0x0 CMP_LO, +0x4 CMP_HI.
  - +0x8 CH_CTRL: bit0 ARM, bit1 PERIODIC.
  - +0xC PERIOD, 32-bit.
- Unmapped offsets, and channels >= NUM_CH, read 0 and ignore writes.
- Atomic 64-bit access:
  - Reading CNT_LO returns live cnt[31:0] and latches cnt[CNT_WIDTH-1:32] into a shadow. CNT_HI reads return that shadow.
  - Writing CNT_LO stages the value. Writing CNT_HI commits {wdata, staged} to cnt.
  - CMP_LO/CMP_HI writes are staged and committed the same way. CMP_LO reads return the committed value.
- Prescaler:
  - Internal 16-bit divider; counter tick when divider == PRESCALE, after which the divider returns to 0.
  - Divider is held at 0 while EN=0 and on any CTRL write.
- Counter: +1 per tick, wrapping from all-ones to 0. A committed CNT write takes priority over a tick in the same cycle.
- Channel match: match_k = ARM_k && (cnt >= cmp_k), unsigned, evaluated every cycle. On match:
  - STATUS[k] sets.
  - One-shot: ARM_k clears.
  - Periodic: cmp_k <= cmp_k + PERIOD_k, zero-extended, modulo 2^CNT_WIDTH; ARM_k stays set.
  - PERIOD=0 in periodic mode means match every cycle (legal, documented hazard).
- Simultaneous events:
  - Hardware set wins over a W1C of the same bit.
  - Committed CMP write wins over a periodic reload.
  - CH_CTRL write wins over a one-shot ARM clear.
- Reset values:
  - CTRL=0, cnt=0, cmp=all-ones, staging/shadow=0.
  - STATUS=0, IRQ_EN=0, CH_CTRL=0, PERIOD=0.
  - irq=0, irq_vec=0, mem_rdata=0.
- Reset mid-operation clears all state immediately and asynchronously. Release is on a clk edge.

## Timing
- Register writes take effect at the clk edge of the mem_we cycle.
- Reads are combinational in the mem_re cycle. The CNT_LO shadow latch updates at the edge ending that cycle.
- Match is detected in cycle t. STATUS, ARM and cmp update at the edge ending t. irq/irq_vec go high in t+1 (derived from registered STATUS and IRQ_EN, no extra flop).
- With PRESCALE=0, cnt increments every cycle. With PRESCALE=P, the first tick occurs P+1 cycles after EN is set.
- irq stays high until STATUS bit is cleared or IRQ_EN bit is cleared. After a W1C it drops the cycle after the write edge.

## Test plan
- Reset, read all registers. Required: CTRL/CNT/STATUS/IRQ_EN/CH_CTRL/PERIOD read 0, CMP read all-ones, irq=0.
- EN=1, PRESCALE=3, run 40 cycles. Required: cnt=10 (±1 for the phase of the EN write); CNT_LO read then CNT_HI returns a consistent 48-bit value across a 0xFFFFFFFF->0x1_00000000 carry preloaded via CNT_HI commit.
- Ch0 one-shot, CMP=100, IRQ_EN[0]=1, PRESCALE=0. Required:
  - irq rises exactly one cycle after cnt reaches 100.
  - ARM reads 0.
  - W1C STATUS[0] drops irq; no retrigger.
- Ch1 periodic, CMP=50, PERIOD=20. Required:
  - STATUS[1] sets at cnt 50, 70, 90 (clear between).
  - CMP reads 110 after the third match.
- Preload cnt=2^48-3, ch2 periodic CMP=2^48-1, PERIOD=5. Required:
  - cnt wraps to 0.
  - cmp wraps to 4.
  - Next match at cnt=4.
- Same-cycle W1C of STATUS[0] with a new ch0 match. Required: STATUS[0] remains 1. Then assert rst mid-run: all outputs 0 immediately.

Source files
------------

// File: rtl/multi_timer_if.sv
// Memory-bus and interrupt signals between the core side and multi_timer.
// The master modport is the bus/interrupt-controller side; slave is the timer.
interface multi_timer_if #(
  parameter int NUM_CH = 4
) ();
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       mem_rdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata, irq, irq_vec
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata, irq, irq_vec
  );
endinterface

// File: rtl/multi_timer.sv
// Prescaled free-running counter with NUM_CH compare channels (one-shot or
// periodic), sticky W1C status and per-channel interrupt enables.
module multi_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_3000,
  parameter int          NUM_CH    = 4,
  parameter int          CNT_WIDTH = 48
) (
  input  logic           clk,
  input  logic           rst,
  multi_timer_if.slave   bus
);
  localparam int CW = CNT_WIDTH;

  logic        hit, wr, rd;
  logic [5:0]  word;
  logic        ch_space;
  logic [3:0]  ch_sel;
  logic [1:0]  ch_reg;

  assign hit      = (bus.mem_addr[31:8] == BASE_ADDR[31:8]);
  assign wr       = hit && bus.mem_we;
  assign rd       = hit && bus.mem_re;
  assign word     = 6'(bus.mem_addr[7:0] >> 2);
  assign ch_space = (word[5:3] != 3'd0);
  assign ch_sel   = word[5:2] - 4'd2;
  assign ch_reg   = word[1:0];

  logic wr_ctrl, wr_cnt_lo, wr_cnt_hi, wr_status, wr_irq_en, rd_cnt_lo;
  assign wr_ctrl   = wr && (word == 6'd0);
  assign wr_cnt_lo = wr && (word == 6'd1);
  assign wr_cnt_hi = wr && (word == 6'd2);
  assign wr_status = wr && (word == 6'd3);
  assign wr_irq_en = wr && (word == 6'd4);
  assign rd_cnt_lo = rd && (word == 6'd1);

  logic              en_q;
  logic [15:0]       prescale_q;
  logic [15:0]       div_q, div_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       cnt_stage_q;
  logic [31:0]       cnt_shadow_q;
  logic [NUM_CH-1:0] status_q, status_d;
  logic [NUM_CH-1:0] irq_en_q;
  logic [NUM_CH-1:0] match;
  logic              tick;

  assign tick = en_q && (div_q == prescale_q);

  always_comb begin
    div_d = div_q + 16'd1;
    if (wr_ctrl || !en_q || tick) div_d = '0;
    // A committed CNT write overrides the tick of the same cycle.
    cnt_d = cnt_q;
    if (wr_cnt_hi)  cnt_d = CW'({bus.mem_wdata, cnt_stage_q});
    else if (tick)  cnt_d = cnt_q + CW'(1);
    status_d = status_q;
    if (wr_status) status_d = status_q & ~bus.mem_wdata[NUM_CH-1:0];
    status_d = status_d | match;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q         <= 1'b0;
      prescale_q   <= '0;
      div_q        <= '0;
      cnt_q        <= '0;
      cnt_stage_q  <= '0;
      cnt_shadow_q <= '0;
      status_q     <= '0;
      irq_en_q     <= '0;
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      if (wr_ctrl) begin
        en_q       <= bus.mem_wdata[0];
        prescale_q <= bus.mem_wdata[31:16];
      end
      if (wr_cnt_lo) cnt_stage_q  <= bus.mem_wdata;
      if (rd_cnt_lo) cnt_shadow_q <= 32'(cnt_q >> 32);
      if (wr_irq_en) irq_en_q     <= bus.mem_wdata[NUM_CH-1:0];
    end
  end

  logic [31:0] ch_rdata [16];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CW-1:0] cmp_q, cmp_d;
    logic [31:0]   stage_q, period_q;
    logic          arm_q, arm_d, periodic_q;
    logic          sel, wr_lo, wr_hi, wr_ctl, wr_per, match_k;

    assign sel    = ch_space && (ch_sel == 4'(gi));
    assign wr_lo  = wr && sel && (ch_reg == 2'd0);
    assign wr_hi  = wr && sel && (ch_reg == 2'd1);
    assign wr_ctl = wr && sel && (ch_reg == 2'd2);
    assign wr_per = wr && sel && (ch_reg == 2'd3);

    assign match_k   = arm_q && (cnt_q >= cmp_q);
    assign match[gi] = match_k;

    // Software writes take priority over the reload / one-shot disarm.
    always_comb begin
      cmp_d = cmp_q;
      arm_d = arm_q;
      if (wr_hi)                       cmp_d = CW'({bus.mem_wdata, stage_q});
      else if (match_k && periodic_q)  cmp_d = cmp_q + CW'(period_q);
      if (wr_ctl)                      arm_d = bus.mem_wdata[0];
      else if (match_k && !periodic_q) arm_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cmp_q      <= '1;
        stage_q    <= '0;
        period_q   <= '0;
        arm_q      <= 1'b0;
        periodic_q <= 1'b0;
      end else begin
        cmp_q <= cmp_d;
        arm_q <= arm_d;
        if (wr_lo)  stage_q    <= bus.mem_wdata;
        if (wr_ctl) periodic_q <= bus.mem_wdata[1];
        if (wr_per) period_q   <= bus.mem_wdata;
      end
    end

    assign ch_rdata[gi] = (ch_reg == 2'd0) ? cmp_q[31:0] :
                          (ch_reg == 2'd1) ? 32'(cmp_q >> 32) :
                          (ch_reg == 2'd2) ? {30'd0, periodic_q, arm_q} :
                                             period_q;
  end

  for (genvar gi = NUM_CH; gi < 16; gi++) begin : g_no_ch
    assign ch_rdata[gi] = '0;
  end

  always_comb begin
    bus.mem_rdata = '0;
    if (rd) begin
      if (ch_space) begin
        bus.mem_rdata = ch_rdata[ch_sel];
      end else begin
        case (word)
          6'd0:    bus.mem_rdata = {prescale_q, 15'd0, en_q};
          6'd1:    bus.mem_rdata = cnt_q[31:0];
          6'd2:    bus.mem_rdata = cnt_shadow_q;
          6'd3:    bus.mem_rdata = 32'(status_q);
          6'd4:    bus.mem_rdata = 32'(irq_en_q);
          default: bus.mem_rdata = '0;
        endcase
      end
    end
  end

  assign bus.irq_vec = status_q & irq_en_q;
  assign bus.irq     = |(status_q & irq_en_q);
endmodule
